mcast_input_ctrl: RTL and testbench

MCAST_INPUT_CTRL -- requirements
Module: mcast_input_ctrl

---
 rtl/mcast_input_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_mcast_input_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcast_input_ctrl.sv
// ---------------------------------------------------------------------------
// mcast_input_ctrl
//
// Input-port controller for a router input buffer that replays a multicast
// packet once per destination. A head flit with a non-empty candidate mask
// is latched into a "remain" set. Each pass asks the VC allocator for one
// target picked from that set. After the tail of a non-last pass, the FIFO
// read pointer is rewound so the same packet streams out again. Legacy mode
// (MCAST_EN = 0) requests the whole mask in one pass and always pops.
//
// Ports
//   clk_i            clock, all state on the rising edge
//   rstn_i           asynchronous active-low reset
//   fifo_empty_i     input buffer empty
//   flit_type_i      type of the buffer head flit (head / body / tail)
//   flit_fire_i      head-of-buffer flit moved through the crossbar
//   cand_vc_i        route-calculator candidate output mask
//   vc_req_o         request to the VC allocator
//   vc_sel_i         allocator-selected output VC
//   vc_granted_i     allocator grant strobe
//   xb_sel_o         crossbar select
//   pop_o            1 = consume fired flits, 0 = retain them for replay
//   read_reset_o     one-cycle pulse, rewind FIFO read pointer to packet head
//   credit_cnt_i     downstream credits (used only when FC_EN = 1)
//   pass_cnt_o       completed passes of the current packet
//   busy_o           controller is not idle
//   err_empty_cand_o one-cycle pulse, head flit arrived with an empty mask
// ---------------------------------------------------------------------------
module mcast_input_ctrl #(
    parameter int unsigned NPORT      = 5,
    parameter int unsigned MCAST_EN   = 1,
    parameter int unsigned ARB_RR     = 1,
    parameter int unsigned FC_EN      = 0,
    parameter int unsigned FC_PKT_LEN = 16,
    parameter int unsigned CRED_W     = 32
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         fifo_empty_i,
    input  logic [1:0]                   flit_type_i,
    input  logic                         flit_fire_i,
    input  logic [NPORT-1:0]             cand_vc_i,
    output logic [NPORT-1:0]             vc_req_o,
    input  logic [NPORT-1:0]             vc_sel_i,
    input  logic                         vc_granted_i,
    output logic [NPORT-1:0]             xb_sel_o,
    output logic                         pop_o,
    output logic                         read_reset_o,
    input  logic [CRED_W-1:0]            credit_cnt_i,
    output logic [$clog2(NPORT+1)-1:0]   pass_cnt_o,
    output logic                         busy_o,
    output logic                         err_empty_cand_o
);

    localparam int unsigned PCW  = $clog2(NPORT + 1);
    localparam int unsigned PTRW = $clog2(NPORT);

    localparam logic [1:0] FlitBody = 2'b00;
    localparam logic [1:0] FlitHead = 2'b01;
    localparam logic [1:0] FlitTail = 2'b10;

    localparam logic [PTRW-1:0]   LastIdx = PTRW'(NPORT - 1);
    // Gate needs room for the packet minus the two flits the pipeline absorbs.
    localparam logic [CRED_W-1:0] CredThr = CRED_W'(FC_PKT_LEN - 2);
    localparam logic [NPORT-1:0]  OneHot0 = {{(NPORT-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StXfer = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [NPORT-1:0]  remain_q, remain_d;
    logic [NPORT-1:0]  lock_q, lock_d;
    logic [NPORT-1:0]  tgt_q, tgt_d;
    logic [PTRW-1:0]   ptr_q, ptr_d;
    logic [PCW-1:0]    pass_q, pass_d;

    logic              head_vis;
    logic              is_tail;
    logic              gate_open;
    logic              pick_found;
    logic [PTRW-1:0]   pick_idx;
    logic [NPORT-1:0]  target;
    logic              last_pass;
    logic              tail_done;

    // -----------------------------------------------------------------------
    // Shared decode
    // -----------------------------------------------------------------------
    assign head_vis  = ~fifo_empty_i & (flit_type_i == FlitHead);
    assign is_tail   = (flit_type_i == FlitTail);
    assign gate_open = head_vis & ((FC_EN == 0) | (credit_cnt_i >= CredThr));

    // Target pick: first set bit of remain, scanning upward from the RR
    // pointer (or from index 0 in fixed-priority mode) and wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < int'(NPORT); k++) begin
            int j;
            j = (ARB_RR != 0) ? int'(ptr_q) + k : k;
            if (j >= int'(NPORT)) begin
                j = j - int'(NPORT);
            end
            if (!pick_found && remain_q[PTRW'(j)]) begin
                pick_found = 1'b1;
                pick_idx   = PTRW'(j);
            end
        end
    end

    always_comb begin
        target = '0;
        if (MCAST_EN == 0) begin
            target = remain_q;
        end else if (pick_found) begin
            target = OneHot0 << pick_idx;
        end
    end

    // The latched target is what the current pass is serving.
    assign last_pass = (MCAST_EN == 0) || ((remain_q & ~tgt_q) == '0);
    assign tail_done = (state_q == StXfer) & flit_fire_i & is_tail;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= StIdle;
            remain_q <= '0;
            lock_q   <= '0;
            tgt_q    <= '0;
            ptr_q    <= '0;
            pass_q   <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            lock_q   <= lock_d;
            tgt_q    <= tgt_d;
            ptr_q    <= ptr_d;
            pass_q   <= pass_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        lock_d   = lock_q;
        tgt_d    = tgt_q;
        ptr_d    = ptr_q;
        pass_d   = pass_q;
        unique case (state_q)
            StIdle: begin
                if (head_vis && (cand_vc_i != '0)) begin
                    remain_d = cand_vc_i;
                    pass_d   = '0;
                    state_d  = StReq;
                end
            end
            StReq: begin
                if (vc_granted_i) begin
                    lock_d  = vc_sel_i;
                    tgt_d   = target;
                    state_d = StXfer;
                    if (MCAST_EN != 0) begin
                        ptr_d = (pick_idx == LastIdx) ? '0 : pick_idx + PTRW'(1);
                    end
                end
            end
            StXfer: begin
                if (tail_done) begin
                    remain_d = remain_q & ~tgt_q;
                    pass_d   = pass_q + PCW'(1);
                    lock_d   = '0;
                    state_d  = last_pass ? StIdle : StReq;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic
    // -----------------------------------------------------------------------
    always_comb begin
        vc_req_o         = '0;
        xb_sel_o         = '0;
        pop_o            = (MCAST_EN == 0);
        read_reset_o     = 1'b0;
        err_empty_cand_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Qualified by reset so the pulse cannot appear while held in reset.
                err_empty_cand_o = rstn_i & head_vis & (cand_vc_i == '0);
            end
            StReq: begin
                if (gate_open) begin
                    vc_req_o = target;
                end
                if (vc_granted_i) begin
                    xb_sel_o = vc_sel_i;
                end
            end
            StXfer: begin
                xb_sel_o = lock_q;
                if (MCAST_EN != 0) begin
                    pop_o = last_pass;
                end
                read_reset_o = tail_done & ~last_pass;
            end
            default: begin
                vc_req_o = '0;
            end
        endcase
    end

    assign pass_cnt_o = pass_q;
    assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_mcast_input_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for mcast_input_ctrl. Three instances share one stimulus set:
// the default multicast/round-robin build, a credit-gated build and a
// legacy single-pass build. Each scenario task resets everything first.
// ---------------------------------------------------------------------------
module tb_mcast_input_ctrl;

    localparam logic [1:0] BODY = 2'b00;
    localparam logic [1:0] HEAD = 2'b01;
    localparam logic [1:0] TAIL = 2'b10;

    logic        clk, rstn, fifo_empty, flit_fire, vc_granted;
    logic [1:0]  flit_type;
    logic [4:0]  cand_vc, vc_sel;
    logic [31:0] credit;

    logic [4:0] vc_req, xb_sel, fc_vc_req, fc_xb_sel, leg_vc_req, leg_xb_sel;
    logic       pop, read_reset, busy, err;
    logic       fc_pop, fc_rr, fc_busy, fc_err;
    logic       leg_pop, leg_rr, leg_busy, leg_err;
    logic [2:0] pass_cnt, fc_pass_cnt, leg_pass_cnt;

    int nvec, nerr;

    // Observations of the default instance gathered by run_packet.
    logic [4:0] obs_req [16];
    logic       obs_pop [16];
    logic       obs_rr  [16];
    int         obs_lat [16];
    bit         obs_hold[16], obs_xb0[16], obs_xbx[16], obs_popvar[16];
    int         obs_npass;
    bit         obs_tmo, obs_stray;
    logic [2:0] obs_pc;

    // Reference model state.
    int         mptr;
    logic [4:0] exp_tgt [16];
    int         exp_n;

    mcast_input_ctrl #(.NPORT(5), .MCAST_EN(1), .ARB_RR(1), .FC_EN(0), .FC_PKT_LEN(16),
                       .CRED_W(32)) u_dut (
        .clk_i(clk), .rstn_i(rstn), .fifo_empty_i(fifo_empty), .flit_type_i(flit_type),
        .flit_fire_i(flit_fire), .cand_vc_i(cand_vc), .vc_req_o(vc_req), .vc_sel_i(vc_sel),
        .vc_granted_i(vc_granted), .xb_sel_o(xb_sel), .pop_o(pop), .read_reset_o(read_reset),
        .credit_cnt_i(credit), .pass_cnt_o(pass_cnt), .busy_o(busy), .err_empty_cand_o(err)
    );

    mcast_input_ctrl #(.NPORT(5), .MCAST_EN(1), .ARB_RR(1), .FC_EN(1), .FC_PKT_LEN(16),
                       .CRED_W(32)) u_fc (
        .clk_i(clk), .rstn_i(rstn), .fifo_empty_i(fifo_empty), .flit_type_i(flit_type),
        .flit_fire_i(flit_fire), .cand_vc_i(cand_vc), .vc_req_o(fc_vc_req), .vc_sel_i(vc_sel),
        .vc_granted_i(vc_granted), .xb_sel_o(fc_xb_sel), .pop_o(fc_pop),
        .read_reset_o(fc_rr), .credit_cnt_i(credit), .pass_cnt_o(fc_pass_cnt),
        .busy_o(fc_busy), .err_empty_cand_o(fc_err)
    );

    mcast_input_ctrl #(.NPORT(5), .MCAST_EN(0), .ARB_RR(1), .FC_EN(0), .FC_PKT_LEN(16),
                       .CRED_W(32)) u_leg (
        .clk_i(clk), .rstn_i(rstn), .fifo_empty_i(fifo_empty), .flit_type_i(flit_type),
        .flit_fire_i(flit_fire), .cand_vc_i(cand_vc), .vc_req_o(leg_vc_req), .vc_sel_i(vc_sel),
        .vc_granted_i(vc_granted), .xb_sel_o(leg_xb_sel), .pop_o(leg_pop),
        .read_reset_o(leg_rr), .credit_cnt_i(credit), .pass_cnt_o(leg_pass_cnt),
        .busy_o(leg_busy), .err_empty_cand_o(leg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fifo_empty = 1'b1; flit_type = BODY; flit_fire = 1'b0; vc_granted = 1'b0;
        cand_vc = '0; vc_sel = '0; credit = '0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle_inputs();
        tick();
        tick();
        rstn = 1'b1;
        mptr = 0;
    endtask

    // Expected pass order: walk the mask upward from the pointer, wrapping.
    task automatic model_packet(input logic [4:0] cand);
        logic [4:0] rem;
        int j;
        rem   = cand;
        exp_n = 0;
        while (rem != 0) begin
            j = mptr;
            while (!rem[j]) j = (j + 1) % 5;
            exp_tgt[exp_n] = 5'(1 << j);
            rem[j] = 1'b0;
            mptr   = (j + 1) % 5;
            exp_n++;
        end
    endtask

    // Drives one packet through the default instance, answering every request
    // with a grant after gdly cycles, and records what it observed.
    task automatic run_packet(input logic [4:0] cand, input int len, input int gdly);
        int w, p;
        obs_tmo = 0; obs_stray = 0; p = 0;
        fifo_empty = 1'b0; flit_type = HEAD; cand_vc = cand; flit_fire = 1'b0;
        vc_granted = 1'b0; vc_sel = '0;
        tick();
        cand_vc = 5'($urandom);
        while (p < 16) begin
            #1;
            w = 0;
            while (vc_req == 5'b0 && w < 20) begin
                tick(); #1; w++;
            end
            obs_lat[p] = w;
            obs_req[p] = vc_req;
            if (vc_req == 5'b0) begin
                obs_tmo = 1;
                break;
            end
            obs_hold[p] = 1;
            for (int g = 0; g < gdly; g++) begin
                tick(); #1;
                if (vc_req !== obs_req[p]) obs_hold[p] = 0;
            end
            vc_sel = obs_req[p]; vc_granted = 1'b1;
            #1;
            obs_xb0[p] = (xb_sel === obs_req[p]);
            tick();
            vc_granted = 1'b0; vc_sel = 5'($urandom);
            obs_xbx[p] = 1; obs_popvar[p] = 0; obs_rr[p] = 1'b0; obs_pop[p] = 1'b0;
            for (int f = 0; f < len; f++) begin
                flit_type = (f == 0) ? HEAD : ((f == len - 1) ? TAIL : BODY);
                flit_fire = 1'b1;
                #1;
                if (f == 0) obs_pop[p] = pop;
                else if (pop !== obs_pop[p]) obs_popvar[p] = 1;
                if (xb_sel !== obs_req[p]) obs_xbx[p] = 0;
                if (f == len - 1) obs_rr[p] = read_reset;
                else if (read_reset !== 1'b0) obs_stray = 1;
                tick();
            end
            flit_fire = 1'b0; flit_type = HEAD; p++;
            if (busy === 1'b0) break;
        end
        fifo_empty = 1'b1;
        obs_npass  = p;
        #1;
        obs_pc = pass_cnt;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle_inputs();
        fifo_empty = 1'b0; flit_type = HEAD; cand_vc = '0;
        tick();
        nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL rst_err got %b want 0", err); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy got %b want 0", busy); end
        nvec++; if (vc_req !== 5'b0) begin nerr++; $display("FAIL rst_vc_req got %b want 0", vc_req); end
        nvec++; if (xb_sel !== 5'b0) begin nerr++; $display("FAIL rst_xb got %b want 0", xb_sel); end
        nvec++; if (read_reset !== 1'b0) begin nerr++; $display("FAIL rst_rr got %b want 0", read_reset); end
        nvec++; if (pop !== 1'b0) begin nerr++; $display("FAIL rst_pop got %b want 0", pop); end
        nvec++; if (leg_pop !== 1'b1) begin nerr++; $display("FAIL rst_leg_pop got %b want 1", leg_pop); end
        nvec++; if (pass_cnt !== 3'd0) begin nerr++; $display("FAIL rst_pass got %0d want 0", pass_cnt); end
        idle_inputs();
        tick();
        rstn = 1'b1;
        mptr = 0;
        tick();
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL post_rst_busy got %b want 0", busy); end
        nvec++; if (vc_req !== 5'b0) begin nerr++; $display("FAIL post_rst_req got %b want 0", vc_req); end
    endtask

    task automatic test_two_port();
        do_reset();
        run_packet(5'b10100, 4, 0);
        nvec++; if (obs_npass != 2) begin nerr++; $display("FAIL two_npass got %0d want 2", obs_npass); end
        nvec++; if (obs_req[0] !== 5'b00100) begin nerr++; $display("FAIL two_tgt0 got %b want 00100", obs_req[0]); end
        nvec++; if (obs_req[1] !== 5'b10000) begin nerr++; $display("FAIL two_tgt1 got %b want 10000", obs_req[1]); end
        nvec++; if (obs_rr[0] !== 1'b1 || obs_rr[1] !== 1'b0 || obs_stray)
            begin nerr++; $display("FAIL two_rr got %b%b stray %0d want 10 stray 0", obs_rr[0], obs_rr[1], obs_stray); end
        nvec++; if (obs_pop[0] !== 1'b0 || obs_pop[1] !== 1'b1)
            begin nerr++; $display("FAIL two_pop got %b%b want 01", obs_pop[0], obs_pop[1]); end
        nvec++; if (obs_lat[0] != 0 || obs_lat[1] != 0)
            begin nerr++; $display("FAIL two_latency got %0d,%0d want 0,0", obs_lat[0], obs_lat[1]); end
        nvec++; if (obs_pc !== 3'd2) begin nerr++; $display("FAIL two_pass_cnt got %0d want 2", obs_pc); end
    endtask

    task automatic test_rr_wrap();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            run_packet(5'b00011, 3, k);
            nvec++; if (obs_req[0] !== 5'b00001 || obs_req[1] !== 5'b00010 || obs_npass != 2)
                begin nerr++; $display("FAIL rr_pkt%0d got %b,%b n=%0d want 00001,00010 n=2", k, obs_req[0], obs_req[1], obs_npass); end
        end
    endtask

    task automatic test_fc();
        do_reset();
        fifo_empty = 1'b0; flit_type = HEAD; cand_vc = 5'b00100; credit = 32'd13;
        tick();
        for (int c = 0; c < 3; c++) begin
            #1;
            nvec++; if (fc_vc_req !== 5'b0 || fc_busy !== 1'b1)
                begin nerr++; $display("FAIL fc_hold13 got req %b busy %b want 00000 1", fc_vc_req, fc_busy); end
            tick();
        end
        credit = 32'd14;
        #1;
        nvec++; if (fc_vc_req !== 5'b00100) begin nerr++; $display("FAIL fc_open14 got %b want 00100", fc_vc_req); end
        credit = 32'hFFFF_FFFF;
        #1;
        nvec++; if (fc_vc_req !== 5'b00100) begin nerr++; $display("FAIL fc_open_max got %b want 00100", fc_vc_req); end
        credit = 32'd14; fifo_empty = 1'b1;
        #1;
        nvec++; if (fc_vc_req !== 5'b0) begin nerr++; $display("FAIL fc_empty got %b want 00000", fc_vc_req); end
    endtask

    task automatic test_legacy();
        do_reset();
        fifo_empty = 1'b0; flit_type = HEAD; cand_vc = 5'b01010;
        tick();
        #1;
        nvec++; if (leg_vc_req !== 5'b01010 || leg_pop !== 1'b1)
            begin nerr++; $display("FAIL leg_req got %b pop %b want 01010 1", leg_vc_req, leg_pop); end
        vc_sel = 5'b01010; vc_granted = 1'b1;
        #1;
        nvec++; if (leg_xb_sel !== 5'b01010) begin nerr++; $display("FAIL leg_xb_grant got %b want 01010", leg_xb_sel); end
        tick();
        vc_granted = 1'b0; vc_sel = 5'b0;
        for (int f = 0; f < 3; f++) begin
            flit_type = (f == 0) ? HEAD : ((f == 2) ? TAIL : BODY); flit_fire = 1'b1;
            #1;
            nvec++; if (leg_pop !== 1'b1 || leg_rr !== 1'b0 || leg_xb_sel !== 5'b01010)
                begin nerr++; $display("FAIL leg_xfer%0d got pop %b rr %b xb %b want 1 0 01010", f, leg_pop, leg_rr, leg_xb_sel); end
            tick();
        end
        flit_fire = 1'b0; fifo_empty = 1'b1;
        #1;
        nvec++; if (leg_busy !== 1'b0 || leg_pass_cnt !== 3'd1)
            begin nerr++; $display("FAIL leg_done got busy %b pass %0d want 0 1", leg_busy, leg_pass_cnt); end
    endtask

    task automatic test_empty_cand();
        do_reset();
        fifo_empty = 1'b0; flit_type = HEAD; cand_vc = 5'b0;
        #1;
        nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL ecand_pulse got %b want 1", err); end
        tick();
        fifo_empty = 1'b1;
        #1;
        nvec++; if (err !== 1'b0 || busy !== 1'b0)
            begin nerr++; $display("FAIL ecand_after got err %b busy %b want 0 0", err, busy); end
        fifo_empty = 1'b0; flit_type = BODY;
        #1;
        nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL ecand_body got %b want 0", err); end
        // Grant while idle must be ignored.
        fifo_empty = 1'b1; vc_granted = 1'b1; vc_sel = 5'b00001;
        tick();
        vc_granted = 1'b0;
        #1;
        nvec++; if (busy !== 1'b0 || xb_sel !== 5'b0)
            begin nerr++; $display("FAIL idle_grant got busy %b xb %b want 0 00000", busy, xb_sel); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        fifo_empty = 1'b0; flit_type = HEAD; cand_vc = 5'b10101;
        tick();
        for (int p = 0; p < 2; p++) begin
            #1;
            vc_sel = vc_req; vc_granted = 1'b1;
            tick();
            vc_granted = 1'b0;
            for (int f = 0; f < ((p == 0) ? 3 : 1); f++) begin
                flit_type = (f == 0) ? HEAD : ((f == 2) ? TAIL : BODY); flit_fire = 1'b1;
                tick();
            end
            flit_type = HEAD;
        end
        // Now mid-XFER of the second pass.
        #1;
        nvec++; if (busy !== 1'b1 || pass_cnt !== 3'd1)
            begin nerr++; $display("FAIL mid_pre got busy %b pass %0d want 1 1", busy, pass_cnt); end
        #1;
        cand_vc = 5'b0;
        rstn = 1'b0;
        #1;
        nvec++; if (vc_req !== 5'b0 || xb_sel !== 5'b0 || busy !== 1'b0 || pop !== 1'b0 ||
                    read_reset !== 1'b0 || err !== 1'b0 || pass_cnt !== 3'd0)
            begin nerr++; $display("FAIL mid_rst got req %b xb %b busy %b pop %b rr %b err %b pass %0d want all 0",
                                   vc_req, xb_sel, busy, pop, read_reset, err, pass_cnt); end
        idle_inputs();
        tick();
        rstn = 1'b1;
        mptr = 0;
        run_packet(5'b00011, 2, 0);
        nvec++; if (obs_req[0] !== 5'b00001 || obs_npass != 2 || obs_pc !== 3'd2)
            begin nerr++; $display("FAIL mid_restart got tgt0 %b n=%0d pass %0d want 00001 n=2 pass 2", obs_req[0], obs_npass, obs_pc); end
    endtask

    task automatic test_random();
        logic [4:0] cand;
        int len, gdly, n;
        do_reset();
        for (int it = 0; it < 30; it++) begin
            cand = 5'($urandom_range(1, 31));
            len  = $urandom_range(2, 5);
            gdly = $urandom_range(0, 2);
            model_packet(cand);
            run_packet(cand, len, gdly);
            nvec++; if (obs_npass != exp_n || obs_tmo)
                begin nerr++; $display("FAIL rnd%0d_npass got %0d tmo %0d want %0d", it, obs_npass, obs_tmo, exp_n); end
            nvec++; if (obs_pc !== 3'(exp_n))
                begin nerr++; $display("FAIL rnd%0d_pass_cnt got %0d want %0d", it, obs_pc, exp_n); end
            nvec++; if (obs_stray) begin nerr++; $display("FAIL rnd%0d_stray_rr got 1 want 0", it); end
            n = (obs_npass < exp_n) ? obs_npass : exp_n;
            for (int p = 0; p < n; p++) begin
                nvec++; if (obs_req[p] !== exp_tgt[p])
                    begin nerr++; $display("FAIL rnd%0d_tgt%0d got %b want %b", it, p, obs_req[p], exp_tgt[p]); end
                nvec++; if (obs_pop[p] !== (p == exp_n - 1) || obs_popvar[p])
                    begin nerr++; $display("FAIL rnd%0d_pop%0d got %b var %0d want %0d", it, p, obs_pop[p], obs_popvar[p], p == exp_n - 1); end
                nvec++; if (obs_rr[p] !== (p != exp_n - 1))
                    begin nerr++; $display("FAIL rnd%0d_rr%0d got %b want %0d", it, p, obs_rr[p], p != exp_n - 1); end
                nvec++; if (obs_lat[p] != 0 || !obs_hold[p])
                    begin nerr++; $display("FAIL rnd%0d_req%0d latency %0d hold %0d want 0 1", it, p, obs_lat[p], obs_hold[p]); end
                nvec++; if (!obs_xb0[p] || !obs_xbx[p])
                    begin nerr++; $display("FAIL rnd%0d_xb%0d grant %0d lock %0d want 1 1", it, p, obs_xb0[p], obs_xbx[p]); end
            end
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        mptr = 0;
        test_reset();
        test_two_port();
        test_rr_wrap();
        test_fc();
        test_legacy();
        test_empty_cand();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
